// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready payload stream with preamble, SFD, zero pad,
// CRC-32 FCS and inter-frame gap. All GMII outputs are registered.
module gmii_tx_framer #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_PAYLOAD  = 60,
    parameter int unsigned MAX_PAYLOAD  = 1500,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    input  logic       lastIn,
    output logic       readyOut,
    output logic [7:0] txdOut,
    output logic       txEnOut,
    output logic       txErOut,
    output logic       frameDoneOut,
    output logic       abortOut
);

    localparam logic [7:0]  PreLast  = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IfgLast  = 8'(IFG_CYCLES);
    localparam logic [10:0] MinBytes = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MaxBytes = 11'(MAX_PAYLOAD);

    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} stateT;

    stateT       stateQ, stateD;
    logic [7:0]  cntQ, cntD;
    logic [10:0] byteCntQ, byteCntD;
    logic [31:0] crcQ, crcD;
    logic [7:0]  txdQ, txdD;
    logic        txEnQ, txEnD, txErQ, txErD, doneQ, doneD, abortQ, abortD;

    logic [10:0] byteCntInc;
    logic [31:0] crcInv;
    logic        startFrame;

    function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign readyOut   = (stateQ == StSfd) || (stateQ == StData && byteCntQ < MaxBytes);
    assign byteCntInc = byteCntQ + 11'd1;
    assign crcInv     = ~crcQ;

    // State names the kind of byte currently on the wire; outputs for the next cycle are
    // computed here and registered, so state and wire content move together.
    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        byteCntD   = byteCntQ;
        crcD       = crcQ;
        txdD       = 8'h00;
        txEnD      = 1'b0;
        txErD      = 1'b0;
        doneD      = 1'b0;
        abortD     = 1'b0;
        startFrame = 1'b0;
        unique case (stateQ)
            StIdle: startFrame = validIn;
            StPre: begin
                txEnD = 1'b1;
                if (cntQ == PreLast) begin
                    stateD = StSfd;
                    txdD   = 8'hD5;
                end else begin
                    cntD = cntQ + 8'd1;
                    txdD = 8'h55;
                end
            end
            StSfd, StData: begin
                txEnD = 1'b1;
                if (readyOut && validIn) begin
                    txdD     = dataIn;
                    byteCntD = byteCntInc;
                    crcD     = crcByte(crcQ, dataIn);
                    stateD   = StData;
                    if (lastIn) begin
                        cntD   = 8'd0;
                        stateD = (byteCntInc < MinBytes) ? StPad : StFcs;
                    end
                end else begin
                    // Underrun or maximum length: one error byte, then the gap.
                    txErD  = 1'b1;
                    abortD = 1'b1;
                    stateD = StIfg;
                    cntD   = 8'd0;
                end
            end
            StPad: begin
                txEnD = 1'b1;
                if (byteCntQ < MinBytes) begin
                    byteCntD = byteCntInc;
                    crcD     = crcByte(crcQ, 8'h00);
                end else begin
                    txdD   = crcInv[7:0];
                    stateD = StFcs;
                    cntD   = 8'd1;
                end
            end
            StFcs: begin
                if (cntQ < 8'd4) begin
                    txEnD = 1'b1;
                    txdD  = crcInv[{cntQ[1:0], 3'b000} +: 8];
                    doneD = (cntQ == 8'd3);
                    cntD  = cntQ + 8'd1;
                end else begin
                    stateD = StIfg;
                    cntD   = 8'd1;
                end
            end
            StIfg: begin
                if (cntQ == IfgLast) begin
                    stateD     = StIdle;
                    startFrame = validIn;
                end else begin
                    cntD = cntQ + 8'd1;
                end
            end
            default: stateD = StIdle;
        endcase

        if (startFrame) begin
            stateD   = StPre;
            cntD     = 8'd1;
            byteCntD = 11'd0;
            crcD     = 32'hFFFFFFFF;
            txdD     = 8'h55;
            txEnD    = 1'b1;
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            stateQ   <= StIdle;
            cntQ     <= 8'd0;
            byteCntQ <= 11'd0;
            crcQ     <= 32'hFFFFFFFF;
            txdQ     <= 8'h00;
            txEnQ    <= 1'b0;
            txErQ    <= 1'b0;
            doneQ    <= 1'b0;
            abortQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            byteCntQ <= byteCntD;
            crcQ     <= crcD;
            txdQ     <= txdD;
            txEnQ    <= txEnD;
            txErQ    <= txErD;
            doneQ    <= doneD;
            abortQ   <= abortD;
        end
    end

    assign txdOut       = txdQ;
    assign txEnOut      = txEnQ;
    assign txErOut      = txErQ;
    assign frameDoneOut = doneQ;
    assign abortOut     = abortQ;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: expected wire bytes are queued when a frame is driven
// and checked by a monitor as the DUT transmits them.
module tb_gmii_tx_framer;

    logic       clkIn = 1'b0;
    logic       rstIn = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       lastIn = 1'b0;
    logic       readyOut, txEnOut, txErOut, frameDoneOut, abortOut;
    logic [7:0] txdOut;

    always #4 clkIn = ~clkIn;

    gmii_tx_framer dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .dataIn      (dataIn),
        .validIn     (validIn),
        .lastIn      (lastIn),
        .readyOut    (readyOut),
        .txdOut      (txdOut),
        .txEnOut     (txEnOut),
        .txErOut     (txErOut),
        .frameDoneOut(frameDoneOut),
        .abortOut    (abortOut)
    );

    int compared = 0;
    int mismatched = 0;
    int doneCnt = 0;
    int abortCnt = 0;
    int idleRun = 0;
    logic prevEn = 1'b0;
    logic [10:0] expQ[$];      // {frameDone, abort, txEr, txd}
    logic [7:0]  capture[$];
    logic [7:0]  refFrame[$];
    int          gaps[$];
    logic [7:0]  pay[0:1500];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ethernet CRC in non-reflected MSB-first form, bits fed LSB first.
    function automatic logic [31:0] refCrc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[31] ^ d[b];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    function automatic logic [31:0] residue(input int first, input int last);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = first; k <= last; k++) c = refCrc(c, capture[k]);
        return bitrev(c);
    endfunction

    // Queue the wire bytes of a frame; cut < n truncates after cut data bytes.
    task automatic pushFrame(input int n, input int cut, input bit errTail);
        logic [31:0] c, fcs;
        logic [7:0]  b;
        int total;
        for (int k = 0; k < 7; k++) expQ.push_back({3'b000, 8'h55});
        expQ.push_back({3'b000, 8'hD5});
        if (cut < n) begin
            for (int k = 0; k < cut; k++) expQ.push_back({3'b000, pay[k]});
            if (errTail) expQ.push_back({3'b011, 8'h00});
        end else begin
            c = 32'hFFFFFFFF;
            total = (n < 60) ? 60 : n;
            for (int k = 0; k < total; k++) begin
                b = (k < n) ? pay[k] : 8'h00;
                c = refCrc(c, b);
                expQ.push_back({3'b000, b});
            end
            fcs = ~bitrev(c);
            for (int k = 0; k < 4; k++) expQ.push_back({(k == 3), 2'b00, fcs[8*k +: 8]});
        end
    endtask

    task automatic sendFrame(input int n, input bit useLast, input int stallAt,
                             input int resetAt, input bit holdValid);
        int i = 0;
        int cycles = 0;
        bit rdy;
        bit stop = 0;
        bit maxChecked = 0;
        while (!stop) begin
            validIn = (i != stallAt);
            dataIn  = pay[(i > 1500) ? 1500 : i];
            lastIn  = useLast && (i == n - 1);
            rdy     = readyOut;
            @(posedge clkIn);
            #1;
            if (rdy && validIn) i++;
            cycles++;
            if (i == n) stop = 1;
            if (abortOut) stop = 1;
            if (!useLast && i == 1500 && !maxChecked) begin
                check("ready at max length", 32'(readyOut), 32'd0);
                maxChecked = 1;
            end
            if (i == resetAt) begin
                rstIn = 1'b0;
                #1;
                check("outputs in mid-frame reset",
                      {20'h0, txdOut, txEnOut, txErOut, readyOut, frameDoneOut}, 32'd0);
                check("abort in mid-frame reset", 32'(abortOut), 32'd0);
                stop = 1;
            end
            if (cycles > 4000) begin
                check("send cycle budget", 32'(cycles), 32'd4000);
                stop = 1;
            end
        end
        if (!holdValid) begin
            validIn = 1'b0;
            lastIn  = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(posedge clkIn);
            #1;
            n++;
        end while ((expQ.size() != 0 || txEnOut) && n < 5000);
        check("drain within budget", 32'(n < 5000), 32'd1);
    endtask

    // Wire monitor: every enabled cycle must match the head of the expected queue.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clkIn);
            if (rstIn) begin
                if (txEnOut) begin
                    if (!prevEn) gaps.push_back(idleRun);
                    idleRun = 0;
                    capture.push_back(txdOut);
                    check("wire byte expected", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        check("wire byte", {21'h0, frameDoneOut, abortOut, txErOut, txdOut},
                              {21'h0, e});
                    end
                end else begin
                    idleRun++;
                    check("idle outputs", {21'h0, frameDoneOut, abortOut, txErOut, txdOut},
                          32'd0);
                end
                prevEn = txEnOut;
                if (frameDoneOut) doneCnt++;
                if (abortOut) abortCnt++;
            end else begin
                prevEn  = 1'b0;
                idleRun = 0;
            end
        end
    end

    initial begin
        bit same;
        // Reset state
        repeat (2) @(posedge clkIn);
        #1;
        check("reset txd", 32'(txdOut), 32'd0);
        check("reset flags", {27'h0, txEnOut, txErOut, readyOut, frameDoneOut, abortOut}, 32'd0);
        @(negedge clkIn);
        rstIn = 1'b1;
        @(posedge clkIn);
        #1;
        check("idle ready", 32'(readyOut), 32'd0);

        // 60-byte payload, no stalls
        for (int k = 0; k < 60; k++) pay[k] = 8'(k);
        capture.delete();
        pushFrame(60, 60, 0);
        sendFrame(60, 1, -1, -1, 0);
        waitIdle();
        check("t1 enabled cycles", 32'(capture.size()), 32'd72);
        check("t1 frameDone count", 32'(doneCnt), 32'd1);
        if (capture.size() == 72) check("t1 residue", residue(8, 71), 32'hDEBB20E3);
        refFrame = capture;

        // 9-byte payload padded to 60
        for (int k = 0; k < 9; k++) pay[k] = 8'h31 + 8'(k);
        capture.delete();
        pushFrame(9, 9, 0);
        sendFrame(9, 1, -1, -1, 0);
        waitIdle();
        check("t2 enabled cycles", 32'(capture.size()), 32'd72);
        check("t2 frameDone count", 32'(doneCnt), 32'd2);
        if (capture.size() == 72) check("t2 residue", residue(8, 71), 32'hDEBB20E3);

        // Underrun at payload byte 20
        for (int k = 0; k < 40; k++) pay[k] = 8'(k + 100);
        capture.delete();
        pushFrame(40, 20, 1);
        sendFrame(40, 1, 20, -1, 0);
        waitIdle();
        check("t3 abort count", 32'(abortCnt), 32'd1);
        check("t3 frameDone count", 32'(doneCnt), 32'd2);
        check("t3 enabled cycles", 32'(capture.size()), 32'd29);
        check("t3 ready in gap", 32'(readyOut), 32'd0);

        // 1501 bytes without lastIn, valid kept high into the next test
        for (int k = 0; k <= 1500; k++) pay[k] = 8'($urandom_range(0, 255));
        pushFrame(1501, 1500, 1);
        sendFrame(1501, 0, -1, -1, 1);
        @(negedge clkIn);
        #1;
        check("t4 abort count", 32'(abortCnt), 32'd2);
        check("t4 frameDone count", 32'(doneCnt), 32'd2);

        // Two back-to-back 64-byte frames with validIn held high
        for (int k = 0; k < 64; k++) pay[k] = 8'(k * 3 + 1);
        capture.delete();
        pushFrame(64, 64, 0);
        sendFrame(64, 1, -1, -1, 1);
        pushFrame(64, 64, 0);
        sendFrame(64, 1, -1, -1, 0);
        waitIdle();
        check("t5 enabled cycles", 32'(capture.size()), 32'd152);
        check("t5 frameDone count", 32'(doneCnt), 32'd4);
        check("t5 gap after abort", 32'(gaps[gaps.size()-2]), 32'd12);
        check("t5 gap between frames", 32'(gaps[gaps.size()-1]), 32'd12);
        if (capture.size() == 152) check("t5 second residue", residue(84, 151), 32'hDEBB20E3);

        // Reset during payload byte 30, then a clean 60-byte frame
        for (int k = 0; k < 60; k++) pay[k] = 8'(k);
        pushFrame(60, 29, 0);
        sendFrame(60, 1, -1, 30, 0);
        repeat (3) @(posedge clkIn);
        #1;
        check("t6 truncated frame drained", 32'(expQ.size()), 32'd0);
        expQ.delete();
        rstIn = 1'b1;
        capture.delete();
        pushFrame(60, 60, 0);
        sendFrame(60, 1, -1, -1, 0);
        waitIdle();
        same = (capture.size() == refFrame.size());
        for (int k = 0; k < capture.size() && same; k++) same = (capture[k] === refFrame[k]);
        check("t6 frame identical to t1", 32'(same), 32'd1);
        check("t6 frameDone count", 32'(doneCnt), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
